// File: rtl/expu_share_arbiter_if.sv
// Requester, exp-core and response signals of the shared exp arbiter.
interface expu_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 16
) ();
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic [N_REQ-1:0][WIDTH-1:0] req_op_i;
  logic [WIDTH-1:0]            exp_op_o;
  logic [WIDTH-1:0]            exp_res_i;
  logic                        resp_valid_o;
  logic                        resp_ready_i;
  logic [ID_W-1:0]             resp_id_o;
  logic [WIDTH-1:0]            resp_res_o;

  // Requesters, exp core and response consumer
  modport master (
    output req_valid_i, req_op_i, exp_res_i, resp_ready_i,
    input  req_ready_o, exp_op_o, resp_valid_o, resp_id_o, resp_res_o
  );

  // Arbiter side
  modport slave (
    input  req_valid_i, req_op_i, exp_res_i, resp_ready_i,
    output req_ready_o, exp_op_o, resp_valid_o, resp_id_o, resp_res_o
  );
endinterface

// File: rtl/expu_share_arbiter.sv
// Round-robin sharing of one combinational exp core among N_REQ requesters,
// with an elastic tagged result pipeline onto a single response channel.
module expu_share_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  expu_share_arbiter_if.slave  bus,
  output logic                 busy_o
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]                  ptr;
  logic [ID_W-1:0]                  winner;
  logic                             found;
  logic                             accept;
  logic                             hs;
  logic [PIPE_DEPTH-1:0]            in_rdy;
  logic [PIPE_DEPTH-1:0]            stg_vld;
  logic [PIPE_DEPTH-1:0][ID_W-1:0]  stg_id;
  logic [PIPE_DEPTH-1:0][WIDTH-1:0] stg_res;

  // Stage k can take new content when some stage at or above it has a hole
  // (or the consumer is draining the last stage).
  always_comb begin
    logic hole;
    hole   = bus.resp_ready_i;
    in_rdy = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      hole      = hole | ~stg_vld[k];
      in_rdy[k] = hole;
    end
  end

  // Circular search for the first valid requester starting at ptr.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx  = (32'(ptr) + i) % N_REQ;
      cand = ID_W'(idx);
      if (!found && bus.req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign accept = in_rdy[0] & ~clear_i & rst_ni;
  assign hs     = found & accept;

  // Grant and core drive; both forced low while in reset.
  always_comb begin
    bus.req_ready_o = '0;
    bus.exp_op_o    = '0;
    if (found && accept) begin
      bus.req_ready_o[winner] = 1'b1;
    end
    if (found && rst_ni) begin
      bus.exp_op_o = bus.req_op_i[winner];
    end
  end

  // Pointer and result pipeline; clear flushes valids, reset also zeroes payload.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr     <= '0;
      stg_vld <= '0;
      stg_id  <= '0;
      stg_res <= '0;
    end else if (clear_i) begin
      ptr     <= '0;
      stg_vld <= '0;
    end else begin
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (in_rdy[k]) begin
          stg_vld[k] <= stg_vld[k-1];
          if (stg_vld[k-1]) begin
            stg_id[k]  <= stg_id[k-1];
            stg_res[k] <= stg_res[k-1];
          end
        end
      end
      if (in_rdy[0]) begin
        stg_vld[0] <= hs;
        if (hs) begin
          stg_id[0]  <= winner;
          stg_res[0] <= bus.exp_res_i;
        end
      end
      if (hs) begin
        ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
      end
    end
  end

  // Response channel straight from the last stage.
  assign bus.resp_valid_o = stg_vld[PIPE_DEPTH-1];
  assign bus.resp_id_o    = stg_id[PIPE_DEPTH-1];
  assign bus.resp_res_o   = stg_res[PIPE_DEPTH-1];
  assign busy_o           = |stg_vld;
endmodule

// File: doc/expu_share_arbiter.md
# expu_share_arbiter

Shares one combinational Schraudolph exponential core among `N_REQ` independent requesters, such as softmax lanes and the accumulator's renormalisation path. It uses round-robin arbitration with a valid/ready handshake per requester. The granted operand drives the external core, and the result is tagged with the requester ID. The tagged result passes through an elastic `PIPE_DEPTH`-stage register pipeline onto a single shared response channel. The block sits between the softmax datapath's requesters and the exp core instance, which is kept outside so it can be swapped or stubbed.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 16: operand/result width (FP16ALT).
- `PIPE_DEPTH`, 2: result register stages, ≥1.
- `ID_W`, `$clog2(N_REQ)` (localparam): requester tag width.

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is synchronous and active-low.
- `clear_i`  in  1  synchronous flush of all in-flight results and arbiter state.
- `req_valid_i`  in  N_REQ  per-requester operand valid.
- `req_ready_o`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_op_i`  in  N_REQ×WIDTH  per-requester operand.
- `exp_op_o`  out  WIDTH  operand to the shared core.
- `exp_res_i`  in  WIDTH  core result, combinational from `exp_op_o`.
- `resp_valid_o`  out  1  result valid.
- `resp_ready_i`  in  1  result accept.
- `resp_id_o`  out  ID_W  index of the requester that issued the result.
- `resp_res_o`  out  WIDTH  result.
- `busy_o`  out  1  any pipeline stage valid.

## Operation
**Pipeline stages**
- Stage k holds {valid, id, res}.
- Stage k advances when stage k+1 is empty or advancing.
- Stage `PIPE_DEPTH-1` advances when `resp_ready_i` is high.
- Output ports are driven directly by the last stage.

**Issue**
- `accept` = stage 0 is empty or advancing, and `clear_i` is low.
- Winner = first valid requester, searching upward circularly from pointer `ptr`.
- `req_ready_o[winner]` = `accept`. All other ready bits are 0.
- `req_ready_o` may depend on `req_valid_i`; valid must never depend on ready.

**Core drive and capture**
- `exp_op_o` = winner's `req_op_i`, or 0 when no requester is valid.
- On a handshake, stage 0 loads {1, winner, `exp_res_i`}.

**Arbitration pointer**
- After each handshake, `ptr` ← (winner + 1) mod `N_REQ`.
- `ptr` does not change on cycles without a handshake.
- Result: each continuously valid requester is granted at least once every `N_REQ` accepts (no starvation).

**Ordering and stalling**
- Results leave in issue order. No reordering, no drops, no duplicates.
- While `resp_ready_i` is low, `resp_valid_o`, `resp_id_o` and `resp_res_o` hold stable.
- When all stages are full and stalled, every `req_ready_o` is 0.

**Clear**
- `clear_i` high: all stage valids ← 0 and `ptr` ← 0 at the next edge.
- No request is accepted in a `clear_i` cycle; `clear_i` wins over a simultaneous request.
- Data/id registers need not be cleared.

**Reset**
- Same effect as clear, and additionally zeroes data and id.
- Reset mid-operation discards all in-flight results.

## Timing
Reset values:
- `resp_valid_o`=0, `resp_id_o`=0, `resp_res_o`=0, `busy_o`=0.
- `ptr`=0.
- `req_ready_o`=0 and `exp_op_o`=0 while `rst_ni` is low.

Latency:
- A handshake in cycle t gives `resp_valid_o` high in cycle t+`PIPE_DEPTH` when there is no backpressure.

Throughput:
- One accept per cycle while `resp_ready_i` is high.

Skid behaviour:
- With `resp_ready_i` low, `PIPE_DEPTH` further accepts are possible before all ready bits drop.
- Ready rises again in the cycle where `resp_ready_i` is high (same-cycle pass-through).

Other timing rules:
- `busy_o` is combinational from the stage valids.
- `exp_op_o` → `exp_res_i` is a single-cycle combinational path; the core has no registers.

## Test plan
- **Single request through real core:** requester 1 only, op 0x0000, `PIPE_DEPTH`=2, handshake at cycle 10 → `resp_valid_o` at cycle 12 with id=1, res=0x3F80.
- **Full round-robin:** all four requesters valid continuously, stub core res=op+1, ops 0x0100·i → grant order 0,1,2,3,0,1… One response per cycle. Each response's id and res match the issuing requester.
- **Circular search from pointer:** after a grant to requester 2 (`ptr`=3), only requester 1 valid → requester 1 granted in the same cycle; `ptr` becomes 2.
- **Backpressure:** all valid, `resp_ready_i` low for 6 cycles →
  - exactly `PIPE_DEPTH` accepts, then all ready bits 0;
  - outputs held stable throughout;
  - after release, all results delivered in order with no loss.
- **Clear mid-flight:** 2 results in flight, `clear_i` together with `req_valid_i[0]` →
  - no accept that cycle;
  - next cycle `resp_valid_o`=0, `busy_o`=0, `ptr`=0;
  - requester 0 granted the following cycle.
- **Reset mid-operation:** `rst_ni` low for 1 cycle with a full pipeline → all outputs at reset values in the next cycle; no stale response appears afterwards.
